// File: rtl/branch_resolver_pkg.sv
// Shared types for the branch resolver: prediction queue entry, resolver FSM
// states and the debug snapshot exported by the top.
package branch_resolver_pkg;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pred_next;
    logic        pred_taken;
  } q_entry_t;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_e;

  typedef struct packed {
    state_e   state;
    logic     queue_empty;
    q_entry_t head;
  } dbg_t;

  function automatic logic [31:0] seq_next(input logic [31:0] pc);
    return pc + INSTR_BYTES;
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Fetch/EX-facing bus of the branch resolver: push side, resolve side,
// predictor update strobe and fetch redirect.
interface branch_resolver_if;
  // Handshake: a fetch push is accepted on a rising clk edge when
  // fetch_valid=1 and queue_full=0 (queue_full is the ready, inverted);
  // ex_valid has no backpressure, while update_valid and redirect_valid are
  // single-cycle strobes with no ready, qualified by nothing else.
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pred_next;
  logic        fetch_pred_taken;
  logic        queue_full;

  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_is_branch;
  logic        ex_taken;
  logic [31:0] ex_target;

  logic        update_valid;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        update_taken;

  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output fetch_valid, fetch_pc, fetch_pred_next, fetch_pred_taken,
    output ex_valid, ex_pc, ex_is_branch, ex_taken, ex_target,
    input  queue_full,
    input  update_valid, update_pc, update_target, update_taken,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  fetch_valid, fetch_pc, fetch_pred_next, fetch_pred_taken,
    input  ex_valid, ex_pc, ex_is_branch, ex_taken, ex_target,
    output queue_full,
    output update_valid, update_pc, update_target, update_taken,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/branch_resolver_pred_queue.sv
// In-order prediction FIFO with a single-cycle flush; flush wins over any
// push or pop offered in the same cycle.
module branch_resolver_pred_queue
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PTR_BITS = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     flush,
  input  logic     push,
  input  q_entry_t push_data,
  input  logic     pop,
  output q_entry_t head_data,
  output logic     full,
  output logic     empty
);

  localparam logic [PTR_BITS:0] DEPTH_C = (PTR_BITS + 1)'(DEPTH);

  q_entry_t            mem_q [DEPTH];
  q_entry_t            mem_d [DEPTH];
  logic [PTR_BITS-1:0] head_q, head_d;
  logic [PTR_BITS-1:0] tail_q, tail_d;
  logic [PTR_BITS:0]   count_q, count_d;
  logic                push_ok, pop_ok;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign head_data = mem_q[head_q];
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[tail_q] = push_data;
        tail_d        = tail_q + 1'b1;
      end
      if (pop_ok) begin
        head_d = head_q + 1'b1;
      end
      // Pointers wrap naturally because DEPTH is a power of two.
      count_d = count_q + {{PTR_BITS{1'b0}}, push_ok} - {{PTR_BITS{1'b0}}, pop_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolution-side partner of the gshare fetch predictor: checks each resolved
// instruction against its queued prediction, trains the predictor, redirects fetch.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PTR_BITS = 2,
  parameter int CNT_BITS = 32
) (
  input  logic                clk,
  input  logic                reset,
  branch_resolver_if.slave    bus,
  output logic [CNT_BITS-1:0] branch_count,
  output logic [CNT_BITS-1:0] mispredict_count,
  output logic                sync_err,
  output dbg_t                dbg
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  state_e   state_q, state_d;
  logic     running;
  logic     q_full, q_empty;
  logic     push, pop, mispredict;
  q_entry_t head, push_entry;
  logic [31:0] actual_next;

  logic        update_valid_q, update_valid_d;
  logic [31:0] update_pc_q, update_pc_d;
  logic [31:0] update_target_q, update_target_d;
  logic        update_taken_q, update_taken_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [CNT_BITS-1:0] branch_count_q, branch_count_d;
  logic [CNT_BITS-1:0] mispredict_count_q, mispredict_count_d;
  logic        sync_err_q, sync_err_d;

  // RECOVER is the wrong-path bubble: both fetch and EX are ignored.
  assign running     = (state_q == ST_RUN);
  assign pop         = running && bus.ex_valid && !q_empty;
  assign actual_next = (bus.ex_is_branch && bus.ex_taken) ? bus.ex_target : seq_next(head.pc);
  assign mispredict  = pop && (actual_next != head.pred_next);
  assign push        = running && bus.fetch_valid && !q_full && !mispredict;

  assign push_entry = '{pc: bus.fetch_pc, pred_next: bus.fetch_pred_next,
                        pred_taken: bus.fetch_pred_taken};

  branch_resolver_pred_queue #(
    .DEPTH    (DEPTH),
    .PTR_BITS (PTR_BITS)
  ) u_pred_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (mispredict),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (mispredict) state_d = ST_RECOVER;
      ST_RECOVER: state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  always_comb begin
    update_valid_d     = 1'b0;
    update_pc_d        = update_pc_q;
    update_target_d    = update_target_q;
    update_taken_d     = update_taken_q;
    redirect_valid_d   = 1'b0;
    redirect_pc_d      = redirect_pc_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    sync_err_d         = sync_err_q;

    // Only real branches train the predictor; a false BTB hit on a
    // non-branch is corrected through the redirect path alone.
    if (pop && bus.ex_is_branch) begin
      update_valid_d  = 1'b1;
      update_pc_d     = head.pc;
      update_target_d = bus.ex_target;
      update_taken_d  = bus.ex_taken;
      if (branch_count_q != CNT_MAX) branch_count_d = branch_count_q + 1'b1;
    end

    if (mispredict) begin
      redirect_valid_d = 1'b1;
      redirect_pc_d    = actual_next;
      if (mispredict_count_q != CNT_MAX) mispredict_count_d = mispredict_count_q + 1'b1;
    end

    if (running && bus.ex_valid && q_empty) sync_err_d = 1'b1;
    if (pop && (head.pc != bus.ex_pc))      sync_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      update_valid_q     <= 1'b0;
      update_pc_q        <= '0;
      update_target_q    <= '0;
      update_taken_q     <= 1'b0;
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
      sync_err_q         <= 1'b0;
    end else begin
      update_valid_q     <= update_valid_d;
      update_pc_q        <= update_pc_d;
      update_target_q    <= update_target_d;
      update_taken_q     <= update_taken_d;
      redirect_valid_q   <= redirect_valid_d;
      redirect_pc_q      <= redirect_pc_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
      sync_err_q         <= sync_err_d;
    end
  end

  assign bus.queue_full     = running && q_full;
  assign bus.update_valid   = update_valid_q;
  assign bus.update_pc      = update_pc_q;
  assign bus.update_target  = update_target_q;
  assign bus.update_taken   = update_taken_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign branch_count       = branch_count_q;
  assign mispredict_count   = mispredict_count_q;
  assign sync_err           = sync_err_q;

  assign dbg = '{state: state_q, queue_empty: q_empty, head: head};

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed scenarios with hand-derived values, then
// random traffic against a queue-based reference model.
module tb_branch_resolver;
  import branch_resolver_pkg::*;

  localparam int DEPTH    = 4;
  localparam int CNT_BITS = 4;
  localparam int CNT_SAT  = (1 << CNT_BITS) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [CNT_BITS-1:0] branch_count, mispredict_count;
  logic sync_err;
  dbg_t dbg;

  branch_resolver_if bus ();

  branch_resolver #(.DEPTH(DEPTH), .PTR_BITS(2), .CNT_BITS(CNT_BITS)) dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count),
    .sync_err         (sync_err),
    .dbg              (dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: queue of {pc, pred_next} plus expected registered outputs.
  logic [63:0] exp_q[$];
  bit          m_recover;
  logic        m_upd_valid, m_upd_taken, m_red_valid, m_sync;
  logic [31:0] m_upd_pc, m_upd_target, m_red_pc;
  int          m_bc, m_mc;

  task automatic cyc(input bit rst, input bit fv, input logic [31:0] fpc, input logic [31:0] fpn,
                     input bit ev, input logic [31:0] epc, input bit eb, input bit et,
                     input logic [31:0] etgt);
    logic [63:0] e;
    logic [31:0] nxt;
    bit mis, full_now;
    @(negedge clk);
    reset                = rst;
    bus.fetch_valid      = fv;
    bus.fetch_pc         = fpc;
    bus.fetch_pred_next  = fpn;
    bus.fetch_pred_taken = (fpn != fpc + 32'd4);
    bus.ex_valid         = ev;
    bus.ex_pc            = epc;
    bus.ex_is_branch     = eb;
    bus.ex_taken         = et;
    bus.ex_target        = etgt;
    if (rst) begin
      exp_q.delete();
      m_recover = 0; m_upd_valid = 0; m_upd_taken = 0; m_red_valid = 0; m_sync = 0;
      m_upd_pc = 0; m_upd_target = 0; m_red_pc = 0; m_bc = 0; m_mc = 0;
    end else if (m_recover) begin
      m_recover = 0; m_upd_valid = 0; m_red_valid = 0;
    end else begin
      full_now = (exp_q.size() == DEPTH);
      mis = 0; m_upd_valid = 0; m_red_valid = 0;
      if (ev) begin
        if (exp_q.size() == 0) m_sync = 1;
        else begin
          e = exp_q.pop_front();
          if (e[63:32] != epc) m_sync = 1;
          nxt = (eb && et) ? etgt : e[63:32] + 32'd4;
          if (eb) begin
            m_upd_valid = 1; m_upd_pc = e[63:32]; m_upd_target = etgt; m_upd_taken = et;
            if (m_bc < CNT_SAT) m_bc++;
          end
          if (nxt != e[31:0]) begin
            mis = 1; m_red_valid = 1; m_red_pc = nxt;
            if (m_mc < CNT_SAT) m_mc++;
          end
        end
      end
      if (mis) begin
        exp_q.delete();
        m_recover = 1;
      end else if (fv && !full_now) exp_q.push_back({fpc, fpn});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push1(input logic [31:0] pc, input logic [31:0] pn);
    cyc(0, 1, pc, pn, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (bus.update_valid !== 1'b0) begin failures++; $display("FAIL reset_update_valid got=%b exp=0", bus.update_valid); end
    if (bus.redirect_valid !== 1'b0) begin failures++; $display("FAIL reset_redirect_valid got=%b exp=0", bus.redirect_valid); end
    if (branch_count !== '0 || mispredict_count !== '0) begin failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", branch_count, mispredict_count); end
    if (sync_err !== 1'b0) begin failures++; $display("FAIL reset_sync_err got=%b exp=0", sync_err); end
    if (bus.queue_full !== 1'b0) begin failures++; $display("FAIL reset_queue_full got=%b exp=0", bus.queue_full); end
    if (dbg.state !== ST_RUN || dbg.queue_empty !== 1'b1) begin failures++; $display("FAIL reset_state got=%b/%b exp=RUN/empty", dbg.state, dbg.queue_empty); end
  endtask

  task automatic test_not_taken();
    do_reset();
    push1(32'h100, 32'h104);
    cyc(0, 0, 0, 0, 1, 32'h100, 1, 0, 32'h180);
    checks += 5;
    if (bus.update_valid !== 1'b1) begin failures++; $display("FAIL nt_update_valid got=%b exp=1", bus.update_valid); end
    if (bus.update_pc !== 32'h100 || bus.update_taken !== 1'b0) begin failures++; $display("FAIL nt_update_fields got=%h/%b exp=100/0", bus.update_pc, bus.update_taken); end
    if (bus.redirect_valid !== 1'b0) begin failures++; $display("FAIL nt_redirect got=%b exp=0", bus.redirect_valid); end
    if (branch_count !== 4'd1) begin failures++; $display("FAIL nt_branch_count got=%0d exp=1", branch_count); end
    if (mispredict_count !== 4'd0) begin failures++; $display("FAIL nt_mispredict_count got=%0d exp=0", mispredict_count); end
    idle();
    checks += 2;
    if (bus.update_valid !== 1'b0) begin failures++; $display("FAIL nt_update_pulse got=%b exp=0", bus.update_valid); end
    if (bus.update_pc !== 32'h100) begin failures++; $display("FAIL nt_update_hold got=%h exp=100", bus.update_pc); end
  endtask

  task automatic test_taken_mispredict();
    do_reset();
    push1(32'h200, 32'h204);
    push1(32'h204, 32'h208);
    push1(32'h208, 32'h20c);
    cyc(0, 0, 0, 0, 1, 32'h200, 1, 1, 32'h80);
    checks += 5;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h80) begin failures++; $display("FAIL tm_redirect got=%b/%h exp=1/80", bus.redirect_valid, bus.redirect_pc); end
    if (bus.update_valid !== 1'b1 || bus.update_taken !== 1'b1) begin failures++; $display("FAIL tm_update got=%b/%b exp=1/1", bus.update_valid, bus.update_taken); end
    if (bus.update_target !== 32'h80) begin failures++; $display("FAIL tm_update_target got=%h exp=80", bus.update_target); end
    if (mispredict_count !== 4'd1) begin failures++; $display("FAIL tm_mispredict_count got=%0d exp=1", mispredict_count); end
    if (dbg.state !== ST_RECOVER || dbg.queue_empty !== 1'b1) begin failures++; $display("FAIL tm_flush_state got=%b/%b exp=RECOVER/empty", dbg.state, dbg.queue_empty); end
    // Offered during RECOVER: both must be ignored.
    cyc(0, 1, 32'h80, 32'h84, 1, 32'h204, 1, 0, 0);
    checks += 3;
    if (bus.redirect_valid !== 1'b0 || bus.update_valid !== 1'b0) begin failures++; $display("FAIL tm_recover_outputs got=%b/%b exp=0/0", bus.redirect_valid, bus.update_valid); end
    if (sync_err !== 1'b0 || branch_count !== 4'd1) begin failures++; $display("FAIL tm_recover_ignored got=%b/%0d exp=0/1", sync_err, branch_count); end
    if (dbg.state !== ST_RUN || dbg.queue_empty !== 1'b1) begin failures++; $display("FAIL tm_back_to_run got=%b/%b exp=RUN/empty", dbg.state, dbg.queue_empty); end
  endtask

  task automatic test_false_hit();
    do_reset();
    push1(32'h300, 32'h400);
    cyc(0, 0, 0, 0, 1, 32'h300, 0, 0, 32'h0);
    checks += 4;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h304) begin failures++; $display("FAIL fh_redirect got=%b/%h exp=1/304", bus.redirect_valid, bus.redirect_pc); end
    if (bus.update_valid !== 1'b0) begin failures++; $display("FAIL fh_update_valid got=%b exp=0", bus.update_valid); end
    if (branch_count !== 4'd0) begin failures++; $display("FAIL fh_branch_count got=%0d exp=0", branch_count); end
    if (mispredict_count !== 4'd1) begin failures++; $display("FAIL fh_mispredict_count got=%0d exp=1", mispredict_count); end
  endtask

  task automatic test_full();
    logic [31:0] exp_pc[4];
    exp_pc[0] = 32'h504; exp_pc[1] = 32'h508; exp_pc[2] = 32'h50c; exp_pc[3] = 32'h514;
    do_reset();
    for (int i = 0; i < 4; i++) push1(32'h500 + 32'(4 * i), 32'h504 + 32'(4 * i));
    checks++;
    if (bus.queue_full !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", bus.queue_full); end
    cyc(0, 1, 32'h510, 32'h514, 1, 32'h500, 1, 0, 0);
    checks += 2;
    if (bus.update_pc !== 32'h500) begin failures++; $display("FAIL full_pop got=%h exp=500", bus.update_pc); end
    if (bus.queue_full !== 1'b0) begin failures++; $display("FAIL full_push_rejected got=%b exp=0", bus.queue_full); end
    push1(32'h514, 32'h518);
    checks++;
    if (bus.queue_full !== 1'b1) begin failures++; $display("FAIL full_refill got=%b exp=1", bus.queue_full); end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 1, exp_pc[i], 1, 0, 0);
      checks++;
      if (bus.update_pc !== exp_pc[i] || bus.redirect_valid !== 1'b0) begin failures++; $display("FAIL full_drain%0d got=%h/%b exp=%h/0", i, bus.update_pc, bus.redirect_valid, exp_pc[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      pc = 32'h1000 + 32'(4 * i);
      cyc(0, i < 10, pc, pc + 32'd4, i > 0, pc - 32'd4, 1, 0, 0);
      if (i > 0) begin
        checks++;
        if (bus.update_valid !== 1'b1 || bus.update_pc !== pc - 32'd4) begin failures++; $display("FAIL wrap%0d got=%b/%h exp=1/%h", i, bus.update_valid, bus.update_pc, pc - 32'd4); end
      end
    end
    checks += 2;
    if (sync_err !== 1'b0) begin failures++; $display("FAIL wrap_sync_err got=%b exp=0", sync_err); end
    if (branch_count !== 4'd10) begin failures++; $display("FAIL wrap_branch_count got=%0d exp=10", branch_count); end
  endtask

  task automatic test_error_reset();
    do_reset();
    cyc(0, 0, 0, 0, 1, 32'h700, 1, 1, 32'h40);
    checks += 2;
    if (sync_err !== 1'b1) begin failures++; $display("FAIL err_empty_pop got=%b exp=1", sync_err); end
    if (bus.update_valid !== 1'b0 || branch_count !== 4'd0) begin failures++; $display("FAIL err_no_update got=%b/%0d exp=0/0", bus.update_valid, branch_count); end
    push1(32'h600, 32'h604);
    // Reset on the same edge as a mispredicting resolve.
    cyc(1, 0, 0, 0, 1, 32'h600, 1, 1, 32'h40);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks += 3;
    if (bus.redirect_valid !== 1'b0 || bus.update_valid !== 1'b0) begin failures++; $display("FAIL rst_pending got=%b/%b exp=0/0", bus.redirect_valid, bus.update_valid); end
    if (branch_count !== '0 || mispredict_count !== '0 || sync_err !== 1'b0) begin failures++; $display("FAIL rst_clears got=%0d/%0d/%b exp=0/0/0", branch_count, mispredict_count, sync_err); end
    if (dbg.state !== ST_RUN || dbg.queue_empty !== 1'b1) begin failures++; $display("FAIL rst_state got=%b/%b exp=RUN/empty", dbg.state, dbg.queue_empty); end
  endtask

  task automatic test_random();
    logic [31:0] pc_ctr, fpn, hpc, hpn, epc, tgt;
    bit fv, ev, eb, et;
    pc_ctr = 32'h2000;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      fv  = ($urandom_range(0, 3) != 0);
      fpn = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hffff_fffc) : pc_ctr + 32'd4;
      hpc = (exp_q.size() > 0) ? exp_q[0][63:32] : $urandom;
      hpn = (exp_q.size() > 0) ? exp_q[0][31:0] : $urandom;
      if (exp_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        ev  = 1;
        epc = ($urandom_range(0, 40) == 0) ? hpc ^ 32'h10 : hpc;
      end else begin
        ev  = ($urandom_range(0, 60) == 0);
        epc = hpc;
      end
      eb = ($urandom_range(0, 4) != 0);
      if (hpn != hpc + 32'd4) begin
        et  = ($urandom_range(0, 3) != 0);
        tgt = ($urandom_range(0, 2) != 0) ? hpn : ($urandom & 32'hffff_fffc);
      end else begin
        et  = ($urandom_range(0, 4) == 0);
        tgt = $urandom & 32'hffff_fffc;
      end
      cyc(0, fv, pc_ctr, fpn, ev, epc, eb, et, tgt);
      pc_ctr = pc_ctr + 32'd4;
      checks += 6;
      if (bus.update_valid !== m_upd_valid) begin failures++; $display("FAIL rnd_update_valid cyc=%0d got=%b exp=%b", n, bus.update_valid, m_upd_valid); end
      if ({bus.update_pc, bus.update_target, bus.update_taken} !== {m_upd_pc, m_upd_target, m_upd_taken}) begin
        failures++; $display("FAIL rnd_update_fields cyc=%0d got=%h/%h/%b exp=%h/%h/%b", n, bus.update_pc, bus.update_target, bus.update_taken, m_upd_pc, m_upd_target, m_upd_taken);
      end
      if (bus.redirect_valid !== m_red_valid || bus.redirect_pc !== m_red_pc) begin failures++; $display("FAIL rnd_redirect cyc=%0d got=%b/%h exp=%b/%h", n, bus.redirect_valid, bus.redirect_pc, m_red_valid, m_red_pc); end
      if (branch_count !== m_bc[CNT_BITS-1:0] || mispredict_count !== m_mc[CNT_BITS-1:0]) begin
        failures++; $display("FAIL rnd_counters cyc=%0d got=%0d/%0d exp=%0d/%0d", n, branch_count, mispredict_count, m_bc, m_mc);
      end
      if (sync_err !== m_sync) begin failures++; $display("FAIL rnd_sync_err cyc=%0d got=%b exp=%b", n, sync_err, m_sync); end
      if (bus.queue_full !== (!m_recover && exp_q.size() == DEPTH) || (dbg.state == ST_RECOVER) !== m_recover) begin
        failures++; $display("FAIL rnd_full_state cyc=%0d got=%b/%b exp=%b/%b", n, bus.queue_full, dbg.state, !m_recover && exp_q.size() == DEPTH, m_recover);
      end
    end
    checks++;
    if (mispredict_count !== 4'(CNT_SAT)) begin failures++; $display("FAIL rnd_saturation got=%0d exp=%0d", mispredict_count, CNT_SAT); end
  endtask

  initial begin
    reset = 1'b1;
    bus.fetch_valid = 0; bus.fetch_pc = 0; bus.fetch_pred_next = 0; bus.fetch_pred_taken = 0;
    bus.ex_valid = 0; bus.ex_pc = 0; bus.ex_is_branch = 0; bus.ex_taken = 0; bus.ex_target = 0;
    test_reset();
    test_not_taken();
    test_taken_mispredict();
    test_false_hit();
    test_full();
    test_back_to_back();
    test_error_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Resolution-side partner of the gshare fetch predictor.
- Records each fetched instruction's prediction in an in-order queue, then pops the entry when that instruction resolves in EX.
- Compares the actual next PC with the predicted one and drives the predictor update interface (update_valid/pc/target/taken).
- Drives the fetch redirect/flush path and keeps branch/mispredict statistics.

Parameters:
DEPTH, 4, prediction queue entries (power of two)
PTR_BITS, 2, log2(DEPTH)
CNT_BITS, 32, width of statistics counters

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
fetch_valid  input  1  push request: instruction fetched this cycle
fetch_pc  input  32  PC of fetched instruction
fetch_pred_next  input  32  predicted next PC from predictor
fetch_pred_taken  input  1  predictor taken bit
queue_full  output  1  combinational, count==DEPTH; fetch must stall
ex_valid  input  1  oldest in-flight instruction resolves this cycle
ex_pc  input  32  PC of resolving instruction (consistency check)
ex_is_branch  input  1  instruction is a branch/jal/jalr
ex_taken  input  1  actual direction (jal/jalr: 1)
ex_target  input  32  actual taken target
update_valid  output  1  registered predictor update strobe
update_pc  output  32  registered
update_target  output  32  registered
update_taken  output  1  registered
redirect_valid  output  1  registered one-cycle pulse
redirect_pc  output  32  registered correct next PC
branch_count  output  CNT_BITS  resolved branches
mispredict_count  output  CNT_BITS  mispredictions (branch and non-branch)
sync_err  output  1  sticky: ex_pc mismatch or pop on empty

Behaviour:
- Reset: queue empty (head=tail=count=0), FSM=RUN, all outputs 0, counters 0, sync_err 0.
- Queue entry: {pc, pred_next, pred_taken}. Push when fetch_valid && !queue_full && state==RUN && no mispredict this cycle.
- Pop when ex_valid && count!=0 && state==RUN.
- Push and pop in the same cycle: count unchanged. queue_full uses the pre-pop count, so no push while full even if popping.
- Pointers wrap modulo DEPTH.
- ex_valid with count==0: no pop, no update, sync_err<=1.
- Popped head.pc != ex_pc: sync_err<=1; resolution proceeds normally.
- actual_next = (ex_is_branch && ex_taken) ? ex_target : head.pc+4, with 32-bit wrap.
- mispredict = pop && (actual_next != head.pred_next).
- Branch pop: next cycle update_valid=1, update_pc=head.pc, update_target=ex_target, update_taken=ex_taken. branch_count+1.
- Non-branch pop: update_valid=0 next cycle, so the predictor is not trained by non-branches.
- update_valid is a single-cycle pulse. update_pc/target/taken hold their last values while update_valid=0.
- Mispredict:
  - next cycle redirect_valid=1, redirect_pc=actual_next;
  - same edge, the queue is flushed (count=0, head=tail); a push offered that cycle is dropped;
  - mispredict_count+1;
  - FSM goes RUN->RECOVER.
- RECOVER, exactly 1 cycle:
  - fetch_valid and ex_valid are ignored (wrong-path bubbles);
  - queue_full=0;
  - redirect_valid=0 afterwards;
  - FSM returns to RUN.
- Counters saturate at all-ones and do not wrap.
- Reset asserted mid-operation overrides everything on that edge. There is no pending redirect or update after reset deasserts.
- Latency: ex_valid to update/redirect is 1 cycle. The predictor sees update_valid in the same cycle as redirect_valid.

Decomposition:
- Shared package:
  - queue entry struct {pc, pred_next, pred_taken};
  - FSM enum {RUN, RECOVER};
  - constant INSTR_BYTES=4.
- One natural sub-module: pred_queue, a synchronous FIFO with a flush input, push/pop, full/empty and head read-out.
- branch_resolver owns the compare, FSM, output registers and counters.

Test Plan:
- Correct not-taken branch: push pc=0x100, pred_next=0x104; ex_valid, ex_is_branch=1, ex_taken=0, ex_pc=0x100 -> next cycle update_valid=1, update_pc=0x100, update_taken=0; redirect_valid=0; branch_count=1; mispredict_count=0.
- Taken branch mispredict: push 0x200 (pred 0x204), then 0x204, 0x208; resolve 0x200 with taken=1, target=0x80 -> next cycle redirect_valid=1, redirect_pc=0x80, update_taken=1, update_target=0x80; queue empty; RECOVER drops an ex_valid offered that cycle; mispredict_count=1.
- False BTB hit on non-branch: push pc=0x300, pred_next=0x400; resolve with ex_is_branch=0 -> redirect_pc=0x304, update_valid=0, branch_count unchanged, mispredict_count+1.
- Full queue with simultaneous push/pop: push 4 entries -> queue_full=1; fetch_valid plus a correct pop -> pop accepted, push rejected, count=3; next cycle a push succeeds.
- Pointer wrap: 10 back-to-back push/pop pairs with correct predictions -> every update_pc matches push order; no sync_err.
- Error and reset: ex_valid on empty queue -> sync_err=1, no update. Then reset during a pending mispredict cycle -> redirect_valid=0, counters=0, sync_err=0, state RUN.
